// File: rtl/multdiv_sequencer_if.sv
// multdiv_sequencer_if
//   Handshake bundle between the execute stage / iterative mul-div datapath
//   and the multdiv_sequencer control FSM.
//   master : execute/datapath side - drives start pulses and datapath flags,
//            receives enables, iteration index and completion status.
//   slave  : sequencer side - the mirror image.
//   Signals:
//     ctrl_mult, ctrl_div   single-cycle start pulses
//     divisor_zero          divisor operand == 0 (valid with ctrl_div)
//     mult_ovf              64-to-32 product overflow (valid in last RUN cycle)
//     load_en, step_en      datapath register enables
//     op_div                1 = divide, 0 = multiply
//     iter_count [CW]       current iteration index
//     busy                  operation in LOAD/RUN
//     data_ready            one-cycle completion pulse
//     data_exception        divide-by-zero / multiply overflow, with data_ready
interface multdiv_sequencer_if #(
  parameter int CW = 6
);
  logic          ctrl_mult;
  logic          ctrl_div;
  logic          divisor_zero;
  logic          mult_ovf;
  logic          load_en;
  logic          step_en;
  logic          op_div;
  logic [CW-1:0] iter_count;
  logic          busy;
  logic          data_ready;
  logic          data_exception;

  modport master (
    output ctrl_mult, ctrl_div, divisor_zero, mult_ovf,
    input  load_en, step_en, op_div, iter_count, busy, data_ready, data_exception
  );

  modport slave (
    input  ctrl_mult, ctrl_div, divisor_zero, mult_ovf,
    output load_en, step_en, op_div, iter_count, busy, data_ready, data_exception
  );
endinterface

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer
//   Control FSM for the iterative multiply/divide datapath. Accepts start
//   pulses, sequences LOAD -> RUN (ITER steps) -> DONE, counts iterations and
//   reports completion plus divide-by-zero / multiply-overflow exceptions.
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous, active-high; clears all state
//     bus    multdiv_sequencer_if slave modport (see interface header)
//   Parameters:
//     ITER   iterations per operation (2..64)
//     CW     width of iter_count, 2**CW > ITER
//   Every output is decoded from state flops or is a flop itself; inputs never
//   reach outputs combinationally.
module multdiv_sequencer #(
  parameter int ITER = 32,
  parameter int CW   = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  multdiv_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CW-1:0] LAST_ITER = CW'(ITER - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] iter_count_q;
  logic          op_div_q;
  logic          exc_q;
  logic          start;
  logic          last_iter;

  always_comb begin
    start     = bus.ctrl_mult | bus.ctrl_div;
    last_iter = (iter_count_q == LAST_ITER);
  end

  // A start pulse is honoured in every state: from IDLE/DONE it begins a new
  // operation, from LOAD/RUN it aborts the current one.
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = LOAD;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        LOAD:    state_nxt = exc_q ? DONE : RUN;
        RUN:     state_nxt = last_iter ? DONE : RUN;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The exception flag is rewritten on every acceptance. divisor_zero is only
  // meaningful at acceptance, so loading it here both clears the flag for a
  // multiply and marks the LOAD -> DONE short-cut for a divide by zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iter_count_q <= '0;
      op_div_q     <= 1'b0;
      exc_q        <= 1'b0;
    end else if (start) begin
      iter_count_q <= '0;
      op_div_q     <= bus.ctrl_div & ~bus.ctrl_mult;
      exc_q        <= bus.ctrl_div & ~bus.ctrl_mult & bus.divisor_zero;
    end else if (state == RUN) begin
      if (!last_iter) begin
        iter_count_q <= iter_count_q + CW'(1);
      end else if (!op_div_q) begin
        exc_q <= bus.mult_ovf;
      end
    end
  end

  always_comb begin
    bus.load_en        = (state == LOAD);
    bus.step_en        = (state == RUN);
    bus.busy           = (state == LOAD) || (state == RUN);
    bus.data_ready     = (state == DONE);
    bus.data_exception = (state == DONE) && exc_q;
    bus.op_div         = op_div_q;
    bus.iter_count     = iter_count_q;
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
`timescale 1ns/1ps
module tb_multdiv_sequencer;
  localparam int ITER = 32;
  localparam int CW   = 6;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  multdiv_sequencer_if #(.CW(CW)) bus ();

  multdiv_sequencer #(.ITER(ITER), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_outs(input string tag, input bit ld, st, bsy, rdy, exc, od, input int it);
    check({tag, ".load_en"},        32'(bus.load_en),        32'(ld));
    check({tag, ".step_en"},        32'(bus.step_en),        32'(st));
    check({tag, ".busy"},           32'(bus.busy),           32'(bsy));
    check({tag, ".data_ready"},     32'(bus.data_ready),     32'(rdy));
    check({tag, ".data_exception"}, 32'(bus.data_exception), 32'(exc));
    check({tag, ".op_div"},         32'(bus.op_div),         32'(od));
    check({tag, ".iter_count"},     32'(bus.iter_count),     32'(it));
  endtask

  task automatic check_idle(input string tag);
    tick();
    check({tag, ".load_en"},        32'(bus.load_en),        32'd0);
    check({tag, ".step_en"},        32'(bus.step_en),        32'd0);
    check({tag, ".busy"},           32'(bus.busy),           32'd0);
    check({tag, ".data_ready"},     32'(bus.data_ready),     32'd0);
    check({tag, ".data_exception"}, 32'(bus.data_exception), 32'd0);
  endtask

  // Drive a start pulse during the current cycle (cycle 0); returns in cycle 1.
  task automatic pulse(input bit m, d, dz);
    bus.ctrl_mult    = m;
    bus.ctrl_div     = d;
    bus.divisor_zero = dz;
    tick();
    bus.ctrl_mult    = 1'b0;
    bus.ctrl_div     = 1'b0;
    bus.divisor_zero = 1'b0;
  endtask

  // From cycle 1: LOAD check, ITER RUN cycles, then DONE in cycle ITER+2.
  // mult_ovf is high only in cycle ovf_cyc; divisor_zero is held high during
  // RUN where it must be ignored. Returns at the DONE cycle.
  task automatic run_body(input int ovf_cyc, input bit exp_exc, input bit exp_div);
    check_outs("load", 1, 0, 1, 0, 0, exp_div, 0);
    bus.mult_ovf = (ovf_cyc == 1);
    for (int c = 2; c <= ITER + 1; c++) begin
      tick();
      check_outs($sformatf("run_c%0d", c), 0, 1, 1, 0, 0, exp_div, c - 2);
      bus.mult_ovf     = (c == ovf_cyc);
      bus.divisor_zero = 1'b1;
    end
    tick();
    bus.mult_ovf     = 1'b0;
    bus.divisor_zero = 1'b0;
    check_outs("done", 0, 0, 0, 1, exp_exc, exp_div, ITER - 1);
  endtask

  task automatic run_op(input bit m, d, input int ovf_cyc, input bit exp_exc, input bit exp_div);
    pulse(m, d, 1'b0);
    run_body(ovf_cyc, exp_exc, exp_div);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rdy_seen;
    bus.ctrl_mult    = 1'b0;
    bus.ctrl_div     = 1'b0;
    bus.divisor_zero = 1'b0;
    bus.mult_ovf     = 1'b0;
    reset            = 1'b1;
    tick();
    tick();
    check_outs("reset", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();

    // Plain multiply, no overflow
    run_op(1, 0, 0, 0, 0);
    check_idle("mul_idle");

    // Divide by zero short-cut
    pulse(0, 1, 1);
    check_outs("dz_load", 1, 0, 1, 0, 0, 1, 0);
    tick();
    check_outs("dz_done", 0, 0, 0, 1, 1, 1, 0);
    check_idle("dz_idle");

    // Overflow sampled only in the last RUN cycle
    run_op(1, 0, ITER + 1, 1, 0);
    check_idle("ovf_idle");
    run_op(1, 0, 20, 0, 0);
    check_idle("ovf20_idle");

    // Multiply aborted by a divide in cycle 10
    pulse(1, 0, 0);
    check_outs("abort_load", 1, 0, 1, 0, 0, 0, 0);
    for (int c = 2; c <= 10; c++) begin
      tick();
      check_outs($sformatf("abort_c%0d", c), 0, 1, 1, 0, 0, 0, c - 2);
    end
    run_op(0, 1, 0, 0, 1);
    check_idle("abort_idle");

    // Asynchronous reset mid-RUN at iter_count 15
    pulse(0, 1, 0);
    for (int c = 2; c <= 17; c++) tick();
    check("pre_reset.iter_count", 32'(bus.iter_count), 32'd15);
    #2 reset = 1'b1;
    #1 check_outs("async_reset", 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    rdy_seen = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.data_ready) rdy_seen++;
    end
    check("post_reset.no_ready", 32'(rdy_seen), 32'd0);
    run_op(0, 1, 0, 0, 1);
    check_idle("div_idle");

    // Simultaneous starts -> multiply; divide chained in the DONE cycle
    run_op(1, 1, 0, 0, 0);
    pulse(0, 1, 0);
    run_body(0, 0, 1);
    check_idle("chain_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Control FSM for the processor's iterative multiply/divide datapath: operand registers, running product/remainder register, and iteration counter.
- Accepts single-cycle start pulses from the execute stage.
- Drives the load and step enables of the datapath registers and counts the iterations.
- Reports completion and exceptions back to the pipeline stall logic.

Parameters:
- ITER, 32, iterations per operation: 32 for radix-2 divide/Booth, 16 for modified Booth; legal range 2..64.
- CW, 6, width of iter_count; must satisfy 2^CW > ITER.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- ctrl_mult  input  1  start multiply; single-cycle pulse; operands valid in the same cycle.
- ctrl_div  input  1  start divide; single-cycle pulse; operands valid in the same cycle.
- divisor_zero  input  1  datapath flag, divisor operand == 0; sampled only in the cycle ctrl_div is accepted.
- mult_ovf  input  1  datapath overflow flag for the 64-to-32 product; sampled only in the final RUN cycle of a multiply.
- load_en  output  1  enable for operand/working registers; latches operands and initial value.
- step_en  output  1  enable for product/remainder registers; one iteration per cycle.
- op_div  output  1  1 = current operation is divide; 0 = multiply. Held stable from LOAD through DONE.
- iter_count  output  CW  index of the current iteration during RUN, 0..ITER-1.
- busy  output  1  high in LOAD and RUN.
- data_ready  output  1  one-cycle completion pulse.
- data_exception  output  1  valid only when data_ready=1; 1 = divide by zero or multiply overflow.

Behaviour:
- States: IDLE, LOAD, RUN, DONE. Encoding is free; all state flops are cleared by reset.
- Reset (any time, including mid-operation):
  - state=IDLE.
  - Every output is 0, including iter_count and op_div.
  - The in-flight operation is discarded with no data_ready.
- Start:
  - In IDLE or DONE, ctrl_mult|ctrl_div sampled high at edge E0 → LOAD for the cycle after E0.
  - If both are high, multiply wins and op_div=0.
- LOAD (exactly 1 cycle):
  - load_en=1, step_en=0, busy=1.
  - Next state: RUN with iter_count=0.
  - Exception: if the accepted op was a divide with divisor_zero=1 at acceptance, next state is DONE instead, with exception flag set.
- RUN (exactly ITER cycles):
  - step_en=1, busy=1.
  - iter_count increments by 1 each edge; it does not wrap during RUN.
  - On the edge leaving iter_count=ITER-1, go to DONE.
  - For a multiply, the exception flag captures mult_ovf in that final cycle.
- DONE (1 cycle):
  - data_ready=1 and data_exception=exception flag; busy=0, step_en=0.
  - iter_count holds ITER-1 (0 on the divide-by-zero path).
  - Next state is IDLE, or LOAD if a new start pulse is present.
- Latency: pulse sampled at edge E0 → data_ready in cycle E0+ITER+2 (34 cycles after the pulse cycle for ITER=32). Divide-by-zero path: data_ready at E0+2.
- Start while busy (LOAD or RUN):
  - The current op is aborted with no data_ready for it.
  - The FSM re-enters LOAD next cycle with the new op; iter_count returns to 0 at the first RUN cycle.
- Start during DONE: the current op still reports data_ready and exception; the new op is in LOAD next cycle.
- Exception flag: cleared on every LOAD entry and on reset; data_exception is 0 whenever data_ready=0.
- Input gating: divisor_zero and mult_ovf are ignored outside their sampling cycles. X on these inputs elsewhere must not propagate into any output.
- Registered outputs: all outputs are registered or decoded purely from state/counter flops; there is no combinational path from input to output.

Test Plan:
- Reset, then ctrl_mult pulse at cycle 0, mult_ovf=0, ITER=32 → load_en=1 in cycle 1; step_en=1 in cycles 2..33 with iter_count 0..31; data_ready=1 and data_exception=0 in cycle 34 only; busy=0 from cycle 34.
- ctrl_div with divisor_zero=1 at cycle 0 → load_en at cycle 1; step_en never asserted; data_ready=1 and data_exception=1 at cycle 2; op_div=1 through cycle 2.
- ctrl_mult with mult_ovf=1 only in the final RUN cycle (cycle 33) → data_exception=1 at cycle 34. Repeat with mult_ovf=1 only in cycle 20 → data_exception=0.
- ctrl_mult at cycle 0, ctrl_div at cycle 10 → no data_ready for the multiply; LOAD at cycle 11; iter_count=0 at cycle 12; data_ready at cycle 44 with op_div=1.
- Assert reset asynchronously (mid-cycle) during RUN at iter_count=15 → all outputs 0 immediately; no data_ready afterward. A following ctrl_div at cycle 0 behaves as in the first scenario's timing.
- ctrl_mult and ctrl_div together → op_div=0. A new ctrl_div pulse in the DONE cycle → data_ready still asserted for the multiply, and load_en=1 the next cycle with op_div=1.
